// File: rtl/freq_mul_if.sv
// freq_mul_if: requester/multiplier handshake bundle between the scheduler and its environment.
interface freq_mul_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] n_cfg;
  logic              lock_valid;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        n_sel;
  logic              adjust;
  logic              busy;
  logic              done;
  logic              timeout_err;
  modport master (input req, n_cfg, lock_valid, output gnt, n_sel, adjust, busy, done, timeout_err);
  modport slave (output req, n_cfg, lock_valid, input gnt, n_sel, adjust, busy, done, timeout_err);
endinterface

// File: rtl/freq_mul_scheduler.sv
// freq_mul_scheduler: round-robin sharing of one frequency-multiplier channel with adjust/valid sequencing and timeout.
module freq_mul_scheduler #(
  parameter int NREQ    = 4,
  parameter int ADJ_CYC = 2,
  parameter int TIMEOUT = 1000
) (
  input logic        clk,
  input logic        rst,
  freq_mul_if.master bus
);
  localparam int W = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, ADJ = 2'd1, WAIT = 2'd2, OWN = 2'd3;
  logic [1:0]      state;
  logic [W-1:0]    last, own, win, c;
  logic [3:0]      cnt;
  logic [15:0]     timer;
  logic [NREQ-1:0] gnt;
  logic [2:0]      n_sel;
  logic            adjust, busy, done, timeout_err;
  logic            held, expire;
  assign held   = bus.req[own];
  assign expire = state == WAIT && held && !bus.lock_valid && timer == 16'(TIMEOUT - 1);
  // Scan backwards so the requester closest after last overrides the rest.
  always_comb begin
    win = last;
    c   = last;
    for (int i = NREQ; i >= 1; i--) begin
      c = W'((int'(last) + i) % NREQ);
      if (bus.req[c]) win = c;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last        <= W'(NREQ - 1);
      own         <= '0;
      cnt         <= '0;
      timer       <= '0;
      gnt         <= '0;
      n_sel       <= '0;
      adjust      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= state == WAIT && held && bus.lock_valid;
      timeout_err <= expire;
      if (state == IDLE) begin
        if (|bus.req) begin
          state  <= ADJ;
          own    <= win;
          gnt    <= NREQ'(1) << win;
          n_sel  <= bus.n_cfg[3*int'(win) +: 3];
          adjust <= 1'b1;
          busy   <= 1'b1;
          cnt    <= '0;
        end
      end else if (!held || expire) begin
        state  <= IDLE;
        gnt    <= '0;
        adjust <= 1'b0;
        busy   <= 1'b0;
        last   <= own;
      end else if (state == ADJ) begin
        if (cnt == 4'(ADJ_CYC - 1)) begin
          adjust <= 1'b0;
          timer  <= '0;
          state  <= WAIT;
        end else cnt <= cnt + 4'd1;
      end else if (state == WAIT) begin
        if (bus.lock_valid) state <= OWN;
        else timer <= timer + 16'd1;
      end
    end
  end
  assign bus.gnt         = gnt;
  assign bus.n_sel       = n_sel;
  assign bus.adjust      = adjust;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_freq_mul_scheduler.sv
// tb_freq_mul_scheduler: directed scenarios checked against a grant-age model every cycle plus literal expectations.
module tb_freq_mul_scheduler;
  localparam int NREQ = 4, ADJ = 2, TO = 20;
  logic clk, rst;
  int   checks = 0, errors = 0;
  freq_mul_if #(.NREQ(NREQ)) bus ();
  freq_mul_scheduler #(.NREQ(NREQ), .ADJ_CYC(ADJ), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: owner index (-1 = none) and cycles elapsed since the grant edge.
  int         m_owner = -1, m_age = 0, m_last = NREQ - 1, m_c;
  bit         m_locked = 0, m_done = 0, m_to = 0;
  logic [2:0] m_nsel = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_age = 0; m_last = NREQ - 1; m_locked = 0; m_done = 0; m_to = 0; m_nsel = 0;
    end else begin
      m_done = 0;
      m_to   = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          m_c = (m_last + k) % NREQ;
          if (bus.req[m_c]) begin
            m_owner = m_c;
            break;
          end
        end
        if (m_owner >= 0) begin
          m_age = 0; m_locked = 0; m_nsel = bus.n_cfg[3*m_owner +: 3];
        end
      end else if (!bus.req[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (!m_locked && m_age >= ADJ && bus.lock_valid) begin
        m_locked = 1; m_done = 1;
      end else if (!m_locked && m_age == ADJ + TO - 1) begin
        m_to = 1; m_last = m_owner; m_owner = -1;
      end else m_age++;
    end
  end
  always @(negedge clk) begin
    chk("gnt", int'(bus.gnt), m_owner < 0 ? 0 : (1 << m_owner));
    chk("adjust", int'(bus.adjust), int'(m_owner >= 0 && m_age < ADJ));
    chk("busy", int'(bus.busy), int'(m_owner >= 0));
    chk("done", int'(bus.done), int'(m_done));
    chk("timeout_err", int'(bus.timeout_err), int'(m_to));
    if (m_owner >= 0) chk("n_sel", int'(bus.n_sel), int'(m_nsel));
  end
  task automatic do_reset();
    bus.req = 0; bus.lock_valid = 0;
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask
  int n_adj, n_done, n, w;
  logic [3:0] ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  initial begin
    rst = 1; bus.req = 0; bus.lock_valid = 0;
    bus.n_cfg = {3'd5, 3'd6, 3'd3, 3'd2};
    #1 rst = 0;
    tick();
    tick();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_n_sel", int'(bus.n_sel), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1;
    tick();
    // single grant to requester 1
    bus.req = 4'b0010; n_adj = 0; n_done = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin
        chk("sg_gnt", int'(bus.gnt), 4'b0010);
        chk("sg_n_sel", int'(bus.n_sel), 3);
      end
      n_adj += int'(bus.adjust);
      n_done += int'(bus.done);
      if (i == 12) bus.lock_valid = 1;
    end
    chk("sg_adjust_cycles", n_adj, 2);
    chk("sg_done_pulses", n_done, 1);
    bus.req = 0; bus.lock_valid = 0;
    tick();
    chk("sg_release_gnt", int'(bus.gnt), 0);
    // round-robin fairness
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      chk("rr_order", int'(bus.gnt), int'(ord[g]));
      w = $clog2(int'(ord[g]));
      bus.lock_valid = 1; n = 0;
      while (!bus.done && n < 10) begin
        tick();
        n++;
      end
      chk("rr_done_seen", int'(bus.done), 1);
      repeat (5) tick();
      bus.req[w] = 0;
      tick();
      chk("rr_gap", int'(bus.gnt), 0);
      bus.req[w] = 1;
      tick();
    end
    // timeout, then round-robin moves past the aborted requester
    do_reset();
    bus.req = 4'b0101;
    tick();
    chk("to_gnt0", int'(bus.gnt), 4'b0001);
    repeat (21) tick();
    chk("to_before", int'(bus.timeout_err), 0);
    tick();
    chk("to_pulse", int'(bus.timeout_err), 1);
    chk("to_gnt_cleared", int'(bus.gnt), 0);
    tick();
    tick();
    chk("to_next_gnt", int'(bus.gnt), 4'b0100);
    bus.req = 0;
    tick();
    tick();
    // abort collides with lock_valid in WAIT
    do_reset();
    bus.req = 4'b0010;
    repeat (5) tick();
    bus.req = 0; bus.lock_valid = 1;
    tick();
    chk("ab_done", int'(bus.done), 0);
    chk("ab_gnt", int'(bus.gnt), 0);
    chk("ab_busy", int'(bus.busy), 0);
    bus.lock_valid = 0;
    tick();
    // no preemption
    do_reset();
    bus.req = 4'b0001; bus.lock_valid = 1;
    tick();
    repeat (3) tick();
    chk("np_done", int'(bus.done), 1);
    bus.req = 4'b1001;
    repeat (6) begin
      tick();
      chk("np_hold", int'(bus.gnt), 4'b0001);
    end
    bus.req = 4'b1000;
    tick();
    chk("np_gap", int'(bus.gnt), 0);
    tick();
    chk("np_next", int'(bus.gnt), 4'b1000);
    bus.req = 0; bus.lock_valid = 0;
    tick();
    tick();
    // asynchronous reset while requester 2 owns
    do_reset();
    bus.req = 4'b0100; bus.lock_valid = 1;
    tick();
    chk("ar_gnt", int'(bus.gnt), 4'b0100);
    repeat (4) tick();
    #2 rst = 0;
    #1;
    chk("ar_async_gnt", int'(bus.gnt), 0);
    chk("ar_async_adjust", int'(bus.adjust), 0);
    chk("ar_async_busy", int'(bus.busy), 0);
    bus.req = 4'b1001;
    tick();
    rst = 1;
    tick();
    chk("ar_first_gnt", int'(bus.gnt), 4'b0001);
    bus.req = 0; bus.lock_valid = 0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_mul_scheduler.md
# freq_mul_scheduler

Shares one frequency-multiplier channel (measurement controller plus datapath) between up to NREQ requesters. Each requester has its own divide exponent n. The block arbitrates round-robin and drives `n_sel` to the datapath. It sequences the multiplier's `adjust` handshake and waits for the multiplier's `valid`. It then holds the grant until the requester releases, or aborts the grant on timeout.

## Interface
- NREQ, 4: number of requesters, legal range 2..8.
- ADJ_CYC, 2: cycles `adjust` is held high per grant, legal range 1..15.
- TIMEOUT, 1000: WAIT cycles allowed before abort, legal range 3..65535.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held high while the requester wants the multiplier.
- n_cfg  in  3*NREQ  packed divide exponents; bits [3i+2:3i] belong to requester i.
- lock_valid  in  1  `valid` output of the multiplier controller.
- gnt  out  NREQ  one-hot grant; all zero when no requester is served.
- n_sel  out  3  exponent routed to the datapath `n` input.
- adjust  out  1  drives the multiplier controller `adjust` input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when lock is first achieved.
- timeout_err  out  1  one-cycle pulse when the WAIT state times out.

## Operation
- States: IDLE, ADJ, WAIT, OWN.
- Round-robin pointer `last` (0..NREQ-1):
  - Search starts at (last+1) mod NREQ.
  - Reset value is NREQ-1, so requester 0 has top priority first.
- IDLE:
  - If any `req` bit is high, pick the winner w.
  - Register gnt=1<<w and n_sel=n_cfg[3w+2:3w]; set adjust=1, busy=1; go to ADJ.
  - n_sel is latched at grant; later changes to n_cfg are ignored until the next grant.
- ADJ:
  - adjust stays high for exactly ADJ_CYC cycles, then drops to 0.
  - On the drop, clear the WAIT timer and go to WAIT.
- WAIT:
  - Timer increments by 1 each cycle.
  - lock_valid=1: done=1 for one cycle; go to OWN.
  - Timer reaches TIMEOUT-1 with no valid: timeout_err=1 for one cycle; gnt=0; last=w; go to IDLE.
- OWN:
  - gnt and n_sel are held. No preemption: other requests wait.
  - When req[w]=0: gnt=0; last=w; go to IDLE.
  - A drop of lock_valid in OWN is ignored.
- Abort:
  - req[w]=0 in ADJ or WAIT: next edge gives gnt=0, adjust=0, last=w; go to IDLE.
  - No done and no timeout_err are produced.
- Simultaneous events in WAIT:
  - req[w] drop together with lock_valid: abort wins, no done.
  - lock_valid on the final timeout cycle: valid wins, done is pulsed, no timeout_err.
- IDLE is entered for at least 1 cycle between grants. gnt never changes owner directly.
- Reset values: gnt=0, n_sel=0, adjust=0, busy=0, done=0, timeout_err=0, state=IDLE, last=NREQ-1, timer=0.

## Timing
- All outputs are registered.
- Grant latency: req sampled high at edge k gives gnt, n_sel and adjust=1 visible after edge k.
- adjust is high after edges k..k+ADJ_CYC-1 and low after edge k+ADJ_CYC.
- WAIT cycle 1 follows edge k+ADJ_CYC.
- lock_valid sampled high at edge m gives done=1 after edge m, cleared after edge m+1.
- Release: req[w] sampled low at edge r gives gnt=0 after edge r. The earliest next grant is after edge r+1.
- Timer width is 16 bits, with no wrap in range because TIMEOUT ≤ 65535.
- Reset while rst is low: outputs go to reset values immediately, with no clock needed. The first grant is evaluated at the first edge after rst rises.

## Test plan
- **Single grant.** NREQ=4, n_cfg requester 1 = 3; req=0010; lock_valid raised 10 cycles into WAIT. Required:
  - gnt=0010 and n_sel=3 one edge after req.
  - adjust high exactly 2 cycles.
  - done pulsed once.
  - req dropped → gnt=0 next edge.
- **Round-robin fairness.** req=1111, each owner releases 5 cycles after done. Required: grant order 0,1,2,3,0 with a 1-cycle IDLE gap each time.
- **Timeout.** TIMEOUT=20, req=0101, lock_valid held 0. Required:
  - timeout_err pulses after the 20th WAIT cycle; gnt=0.
  - The next grant goes to requester 2, not 0.
- **Abort collision.** In WAIT, req[w] drops on the same edge lock_valid rises. Required: done stays 0, gnt=0 next edge, state returns to IDLE.
- **No preemption.** Requester 0 owns; req[3] rises. Required: gnt stays 0001 until req[0] drops, then 1000 after the IDLE cycle.
- **Reset mid-OWN.** Pull rst low asynchronously while requester 2 owns, then release with req=1001. Required:
  - gnt=0 and adjust=0 without a clock edge.
  - After rst rises, requester 0 is granted first.
